// File: rtl/tictactoe_board_controller.sv
// Tic-tac-toe board controller: owns the 3x3 board, alternates human/CPU turns,
// enforces a per-turn timeout and detects win/draw.

module tictactoe_line_chk (
    input  logic [2:0][1:0] cells,
    input  logic [1:0]      code,
    output logic            hit
);
    assign hit = (cells[0] == code) && (cells[1] == code) && (cells[2] == code);
endmodule

module tictactoe_board_controller #(
    parameter int TURN_CYCLES = 50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        p1_valid,
    input  logic [3:0]  p1_pos,
    input  logic        cpu_valid,
    input  logic [3:0]  cpu_pos,
    output logic        cpu_req,
    output logic [17:0] board,
    output logic [1:0]  turn,
    output logic [1:0]  winner,
    output logic        game_over,
    output logic        illegal,
    output logic        timeout
);
    localparam int              CW       = $clog2(TURN_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TURN_CYCLES - 1);
    localparam int              NLINES   = 8;
    // One hex digit per cell index, three cells per line: rows, columns, diagonals.
    localparam logic [NLINES-1:0][11:0] LINES = {12'h246, 12'h048, 12'h258, 12'h147,
                                                 12'h036, 12'h678, 12'h345, 12'h012};

    typedef enum logic [2:0] {
        IDLE, P1_TURN, P1_CHECK, CPU_TURN, CPU_CHECK, DONE
    } state_t;

    state_t          state;
    logic [8:0][1:0] cells;
    logic [CW-1:0]   cnt;
    logic [1:0]      mover;
    logic [NLINES-1:0] line_hit;
    logic            win, full, p1_legal, cpu_legal;

    assign board = cells;
    assign mover = (state == CPU_CHECK) ? 2'b10 : 2'b01;

    genvar gi;
    generate
        for (gi = 0; gi < NLINES; gi++) begin : g_line
            tictactoe_line_chk u_line (
                .cells ({cells[LINES[gi][11:8]], cells[LINES[gi][7:4]], cells[LINES[gi][3:0]]}),
                .code  (mover),
                .hit   (line_hit[gi])
            );
        end
    endgenerate

    assign win = |line_hit;

    always_comb begin
        full = 1'b1;
        for (int k = 0; k < 9; k++)
            if (cells[k] == 2'b00) full = 1'b0;
    end

    // Out-of-range positions short-circuit before the cell lookup.
    assign p1_legal  = p1_valid  && (p1_pos  <= 4'd8) && (cells[p1_pos]  == 2'b00);
    assign cpu_legal = cpu_valid && (cpu_pos <= 4'd8) && (cells[cpu_pos] == 2'b00);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cells     <= '0;
            cnt       <= '0;
            turn      <= 2'b00;
            winner    <= 2'b00;
            game_over <= 1'b0;
            cpu_req   <= 1'b0;
            illegal   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            illegal <= 1'b0;
            timeout <= 1'b0;
            if (start) begin
                state     <= P1_TURN;
                cells     <= '0;
                cnt       <= '0;
                turn      <= 2'b01;
                winner    <= 2'b00;
                game_over <= 1'b0;
                cpu_req   <= 1'b0;
            end else begin
                case (state)
                    P1_TURN: begin
                        if (p1_legal) begin
                            cells[p1_pos] <= 2'b01;
                            state         <= P1_CHECK;
                        end else begin
                            if (p1_valid) illegal <= 1'b1;
                            if (cnt == CNT_LAST) begin
                                timeout <= 1'b1;
                                state   <= CPU_TURN;
                                turn    <= 2'b10;
                                cpu_req <= 1'b1;
                                cnt     <= '0;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
                    CPU_TURN: begin
                        if (cpu_legal) begin
                            cells[cpu_pos] <= 2'b10;
                            state          <= CPU_CHECK;
                            cpu_req        <= 1'b0;
                        end else begin
                            if (cpu_valid) illegal <= 1'b1;
                            if (cnt == CNT_LAST) begin
                                timeout   <= 1'b1;
                                winner    <= 2'b01;
                                state     <= DONE;
                                game_over <= 1'b1;
                                turn      <= 2'b00;
                                cpu_req   <= 1'b0;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
                    P1_CHECK, CPU_CHECK: begin
                        if (win || full) begin
                            winner    <= win ? mover : 2'b11;
                            state     <= DONE;
                            game_over <= 1'b1;
                            turn      <= 2'b00;
                        end else if (state == P1_CHECK) begin
                            state   <= CPU_TURN;
                            turn    <= 2'b10;
                            cpu_req <= 1'b1;
                            cnt     <= '0;
                        end else begin
                            state <= P1_TURN;
                            turn  <= 2'b01;
                            cnt   <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tictactoe_board_controller.sv
// Directed bench for tictactoe_board_controller with TURN_CYCLES=8.

module tb_tictactoe_board_controller;
    logic        clock = 1'b0;
    logic        reset, start, p1_valid, cpu_valid;
    logic [3:0]  p1_pos, cpu_pos;
    logic        cpu_req, game_over, illegal, timeout;
    logic [17:0] board;
    logic [1:0]  turn, winner;
    int          checks = 0;
    int          failures = 0;
    int          seq [9] = '{0, 4, 8, 2, 6, 3, 5, 7, 1};

    tictactoe_board_controller #(.TURN_CYCLES(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .p1_valid  (p1_valid),
        .p1_pos    (p1_pos),
        .cpu_valid (cpu_valid),
        .cpu_pos   (cpu_pos),
        .cpu_req   (cpu_req),
        .board     (board),
        .turn      (turn),
        .winner    (winner),
        .game_over (game_over),
        .illegal   (illegal),
        .timeout   (timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    // Returns just after the accepting edge (controller is in CHECK if legal).
    task automatic mv(input bit cpu, input int pos);
        @(negedge clock);
        if (cpu) begin cpu_valid = 1'b1; cpu_pos = pos[3:0]; end
        else     begin p1_valid  = 1'b1; p1_pos  = pos[3:0]; end
        @(negedge clock);
        cpu_valid = 1'b0;
        p1_valid  = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0;
        p1_valid = 1'b0; p1_pos = '0; cpu_valid = 1'b0; cpu_pos = '0;
        #3;
        chk("rst_board", board, 0);
        chk("rst_turn", turn, 0);
        chk("rst_winner", winner, 0);
        chk("rst_over", game_over, 0);
        chk("rst_req", cpu_req, 0);
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
        chk("idle_turn", turn, 0);

        // Human row win
        do_start();
        chk("start_turn", turn, 2'b01);
        chk("start_board", board, 0);
        mv(0, 0);
        chk("row_b0", board[1:0], 2'b01);
        @(negedge clock);
        chk("row_req_up", cpu_req, 1);
        chk("row_turn_cpu", turn, 2'b10);
        mv(1, 4);
        chk("row_req_down", cpu_req, 0);
        @(negedge clock);
        chk("row_turn_p1", turn, 2'b01);
        mv(0, 1); @(negedge clock);
        mv(1, 8); @(negedge clock);
        mv(0, 2);
        chk("row_b5_0", board[5:0], 6'b010101);
        chk("row_over_early", game_over, 0);
        @(negedge clock);
        chk("row_winner", winner, 2'b01);
        chk("row_over", game_over, 1);
        chk("row_turn_none", turn, 0);
        chk("row_board", board, 18'h20215);
        mv(0, 5);
        chk("done_hold", board, 18'h20215);
        chk("done_no_illegal", illegal, 0);

        // Illegal moves
        do_start();
        mv(0, 9);
        chk("ill_pos9", illegal, 1);
        chk("ill_pos9_board", board, 0);
        chk("ill_pos9_turn", turn, 2'b01);
        @(negedge clock);
        chk("ill_pulse_end", illegal, 0);
        mv(0, 0); @(negedge clock);
        mv(1, 0);
        chk("ill_cpu_occ", illegal, 1);
        chk("ill_cpu_turn", turn, 2'b10);
        chk("ill_cpu_req", cpu_req, 1);
        chk("ill_cpu_board", board, 18'h1);
        @(negedge clock);
        mv(1, 4); @(negedge clock);
        mv(0, 4);
        chk("ill_p1_occ", illegal, 1);
        chk("ill_p1_turn", turn, 2'b01);
        chk("ill_p1_board", board, 18'h201);

        // Draw
        do_start();
        for (int i = 0; i < 9; i++) begin
            mv(i % 2 == 1, seq[i]);
            @(negedge clock);
            if (i == 7) chk("draw_pre_winner", winner, 0);
        end
        chk("draw_winner", winner, 2'b11);
        chk("draw_over", game_over, 1);
        chk("draw_board", board, 18'h196A5);

        // Timeouts: start edge S, human times out at S+8, CPU at S+16
        do_start();
        repeat (7) @(negedge clock);
        chk("to_p1_early", timeout, 0);
        @(negedge clock);
        chk("to_p1_pulse", timeout, 1);
        chk("to_p1_turn", turn, 2'b10);
        chk("to_p1_req", cpu_req, 1);
        chk("to_p1_board", board, 0);
        @(negedge clock);
        chk("to_p1_pulse_end", timeout, 0);
        repeat (6) @(negedge clock);
        chk("to_cpu_early", timeout, 0);
        chk("to_cpu_over_early", game_over, 0);
        @(negedge clock);
        chk("to_cpu_pulse", timeout, 1);
        chk("to_cpu_winner", winner, 2'b01);
        chk("to_cpu_over", game_over, 1);
        chk("to_cpu_req", cpu_req, 0);

        // Legal move in the timeout cycle wins
        do_start();
        repeat (6) @(negedge clock);
        mv(0, 4);
        chk("prec_to_none", timeout, 0);
        chk("prec_to_board", board, 18'h100);
        @(negedge clock);
        chk("prec_to_turn", turn, 2'b10);

        // start beats a simultaneous move
        @(negedge clock); start = 1'b1; p1_valid = 1'b1; p1_pos = 4'd4;
        @(negedge clock); start = 1'b0; p1_valid = 1'b0;
        chk("prec_st_board", board, 0);
        chk("prec_st_turn", turn, 2'b01);
        chk("prec_st_req", cpu_req, 0);

        // Asynchronous reset in CPU_CHECK
        mv(0, 0); @(negedge clock);
        mv(1, 4);
        reset = 1'b0;
        #1;
        chk("arst_board", board, 0);
        chk("arst_turn", turn, 0);
        chk("arst_req", cpu_req, 0);
        chk("arst_winner", winner, 0);
        chk("arst_over", game_over, 0);
        @(negedge clock); reset = 1'b1;
        mv(0, 3);
        chk("arst_idle_board", board, 0);
        chk("arst_idle_turn", turn, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tictactoe_board_controller.md
# tictactoe_board_controller

- Owns the 3x3 board state, alternates turns between the human player and the CPU move generator, and detects win/draw.
- Sits directly downstream of the CPU position generator: it raises a move request, consumes the generator's 0–8 cell index, and commits it to the board.
- Its board output drives the display and feeds occupancy back to the generator.

## Interface
Parameters:
- TURN_CYCLES, default 50_000_000: cycles allowed per turn before timeout (≥2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; clears board and begins a game with the human to move.
- p1_valid  in  1  human move strobe.
- p1_pos  in  4  human cell index, 0–8, row-major.
- cpu_valid  in  1  CPU generator move strobe.
- cpu_pos  in  4  CPU cell index, 0–8, row-major.
- cpu_req  out  1  high while waiting for a CPU move.
- board  out  18  cell k at bits [2k+1:2k]: 00 empty, 01 human, 10 CPU.
- turn  out  2  00 none, 01 human, 10 CPU.
- winner  out  2  00 none, 01 human, 10 CPU, 11 draw.
- game_over  out  1  high in DONE.
- illegal  out  1  one-cycle pulse on a rejected move.
- timeout  out  1  one-cycle pulse on a turn timeout.

## Operation
- **States:** IDLE, P1_TURN, P1_CHECK, CPU_TURN, CPU_CHECK, DONE.
- **Reset (reset=0):** board=0, state=IDLE, turn=00, winner=00, game_over=0, cpu_req=0, illegal=0, timeout=0, counter=0.
- **start:**
  - In any state, start=1 clears board, winner and counter, then enters P1_TURN.
  - start has priority over any move in the same cycle; that move is discarded.
- **Legal move:** pos ≤ 8 and the target cell is 00.
- **P1_TURN (turn=01):**
  - Legal p1_valid writes 01 into the cell, then enters P1_CHECK.
  - Illegal p1_valid pulses illegal, stays in P1_TURN, and does not reset the counter.
  - cpu_valid is ignored.
- **CPU_TURN (turn=10, cpu_req=1):**
  - Legal cpu_valid writes 10, then enters CPU_CHECK.
  - Illegal cpu_valid pulses illegal and stays.
  - p1_valid is ignored.
- **CHECK states (one cycle each):**
  - Evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) for the mover's code.
  - Line found → winner = mover, enter DONE.
  - Else all 9 cells non-empty → winner=11, enter DONE.
  - Else enter the other player's TURN.
- **Turn counter:**
  - Cleared on entering each TURN state; increments every cycle in a TURN state.
  - Human timeout: at count TURN_CYCLES-1 with no legal move, pulse timeout and enter CPU_TURN. The human turn is forfeited and the board is unchanged.
  - CPU timeout: at count TURN_CYCLES-1, pulse timeout, set winner=01, enter DONE.
  - A legal move in the timeout cycle takes precedence over the timeout.
- **DONE:**
  - game_over=1, turn=00.
  - Board and winner hold until start or reset; all moves are ignored.
- **Counter width:** $clog2(TURN_CYCLES); it never wraps.

## Timing
- All outputs are registered.
- A move sampled at edge N shows on board after N. The state is in CHECK during cycle N→N+1.
- winner and game_over update after edge N+1.
- Next-turn latency: cpu_req rises after edge N+1 when the human's move at N does not end the game.
- cpu_req falls after the edge that accepts the CPU move.
- The upstream generator must hold cpu_pos stable while cpu_valid=1. Only one move is accepted per TURN state.
- illegal and timeout pulse for exactly one cycle, after the offending edge.
- reset asserted mid-game returns all outputs to reset values immediately (asynchronously). On deassertion the block stays in IDLE until start.

## Test plan
- **Reset and start:**
  - Stimulus: reset=0, release, then pulse start.
  - Required: board=0, winner=00, game_over=0; turn=01 one cycle after start.
- **Human row win:**
  - Stimulus: human plays 0, 1, 2; CPU plays 4, 8.
  - Required: after the move at 2, board[5:0]=010101, winner=01 and game_over=1 two edges after the move strobe.
- **Illegal moves:**
  - Stimulus: p1_pos=9; then p1_pos of an occupied cell; then CPU plays the occupied cell 0.
  - Required: each pulses illegal for 1 cycle; board is unchanged and the turn is unchanged.
- **Draw:**
  - Stimulus: move sequence 0,4,8,2,6,3,5,7,1 alternating human/CPU.
  - Required: winner=11 after the final CHECK.
- **Timeouts (TURN_CYCLES=8):**
  - Stimulus: human idle 8 cycles.
  - Required: timeout pulse, turn=10, cpu_req=1.
  - Stimulus: then CPU idle 8 cycles.
  - Required: timeout pulse, winner=01, game_over=1.
- **Precedence:**
  - Stimulus: start together with p1_valid=1, pos=4.
  - Required: board=0, state P1_TURN.
  - Stimulus: mid-game, drive reset=0 in CPU_CHECK.
  - Required: all outputs return to reset values before the next edge.
